// File: rtl/battery_monitor_n_if.sv
// Scan request / result bundle between the cell ADC front end and battery_monitor_n.
// master drives sample/bat and reads results; slave is the monitor itself.
interface battery_monitor_n_if #(
  parameter int N_BAT = 2,
  parameter int W     = 4
);
  localparam int SW = W + $clog2(N_BAT);

  logic                 sample;
  logic [N_BAT*W-1:0]   bat;
  logic                 busy;
  logic                 valid;
  logic [SW-1:0]        sum;
  logic [N_BAT-1:0]     discharged;
  logic [4:0]           level;
  logic                 alarm;

  modport master (
    output sample, bat,
    input  busy, valid, sum, discharged, level, alarm
  );

  modport slave (
    input  sample, bat,
    output busy, valid, sum, discharged, level, alarm
  );
endinterface

// File: rtl/battery_monitor_n.sv
// N-channel battery charge monitor: serial scan, 5-level classification with persistence filter.
// Optional persistent fault alarm is built only when BATMON_ALARM_EN is defined.
module battery_monitor_n #(
  parameter int N_BAT = 2,
  parameter int W     = 4,
  parameter int HOLD  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  battery_monitor_n_if.slave bus
);
  localparam int SW = W + $clog2(N_BAT);
  localparam int XW = SW + 4;
  localparam int IW = (N_BAT > 1) ? $clog2(N_BAT) : 1;
  localparam int CW = $clog2(HOLD + 1);

  localparam logic [XW-1:0] S_MAX  = XW'(N_BAT * ((2 ** W) - 1));
  localparam logic [XW-1:0] S_MAX3 = XW'(3 * N_BAT * ((2 ** W) - 1));
  localparam logic [XW-1:0] S_MAX5 = XW'(5 * N_BAT * ((2 ** W) - 1));

  localparam logic [4:0] LVL_CRIT = 5'b00001;
  localparam logic [4:0] LVL_LOW  = 5'b00010;
  localparam logic [4:0] LVL_MED  = 5'b00100;
  localparam logic [4:0] LVL_HIGH = 5'b01000;
  localparam logic [4:0] LVL_FULL = 5'b10000;

  typedef enum logic [1:0] {IDLE, ACCUM, CLASSIFY} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CW'(HOLD)) ? CW'(HOLD) : v + 1'b1;
  endfunction

  // Thresholds are scaled by 8 on the accumulator side so no division is needed.
  function automatic logic [4:0] classify(input logic [SW-1:0] acc);
    logic [XW-1:0] a1;
    logic [XW-1:0] a8;
    a1 = XW'(acc);
    a8 = a1 << 3;
    if (a1 == S_MAX)       return LVL_FULL;
    else if (a8 < S_MAX)   return LVL_CRIT;
    else if (a8 < S_MAX3)  return LVL_LOW;
    else if (a8 < S_MAX5)  return LVL_MED;
    else                   return LVL_HIGH;
  endfunction

  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic [SW-1:0]      r_acc;
  logic [N_BAT-1:0]   r_dis_nxt;
  logic               r_busy;
  logic               r_valid;
  logic [SW-1:0]      r_sum;
  logic [N_BAT-1:0]   r_dis;
  logic [4:0]         r_level;
  logic [4:0]         r_cand;
  logic [CW-1:0]      r_cnt;

  logic [W-1:0]       w_chan;
  logic [4:0]         w_raw;
  logic [CW-1:0]      w_cnt_nxt;

  assign w_chan    = bus.bat[r_idx*W +: W];
  assign w_raw     = classify(r_acc);
  assign w_cnt_nxt = (w_raw == r_cand) ? sat_inc(r_cnt) : CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_acc     <= '0;
      r_dis_nxt <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_sum     <= '0;
      r_dis     <= '0;
      r_level   <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.sample) begin
            r_acc     <= '0;
            r_dis_nxt <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_state   <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc            <= r_acc + SW'(w_chan);
          r_dis_nxt[r_idx] <= (w_chan == '0);
          if (r_idx == IW'(N_BAT - 1)) begin
            r_state <= CLASSIFY;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        CLASSIFY: begin
          r_sum   <= r_acc;
          r_dis   <= r_dis_nxt;
          r_valid <= 1'b1;
          r_cand  <= w_raw;
          r_cnt   <= w_cnt_nxt;
          if (w_cnt_nxt == CW'(HOLD)) r_level <= w_raw;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.valid      = r_valid;
  assign bus.sum        = r_sum;
  assign bus.discharged = r_dis;
  assign bus.level      = r_level;

`ifdef BATMON_ALARM_EN
  logic          r_alarm;
  logic [CW-1:0] r_fcnt;
  logic          w_fault;
  logic [CW-1:0] w_fcnt_nxt;

  // Fault uses the freshly accumulated discharged bits of the scan being classified.
  assign w_fault    = (|r_dis_nxt) || (w_raw == LVL_CRIT);
  assign w_fcnt_nxt = w_fault ? sat_inc(r_fcnt) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
      r_fcnt  <= '0;
    end else if (r_state == CLASSIFY) begin
      r_fcnt  <= w_fcnt_nxt;
      r_alarm <= w_fault && (w_fcnt_nxt == CW'(HOLD));
    end
  end

  assign bus.alarm = r_alarm;
`else
  assign bus.alarm = 1'b0;
`endif

endmodule

// File: tb/tb_battery_monitor_n.sv
// Directed bench for battery_monitor_n: default 2x4-bit HOLD=2 instance plus a 4x8-bit HOLD=1 instance.
module tb_battery_monitor_n;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  battery_monitor_n_if #(.N_BAT(2), .W(4)) bus  ();
  battery_monitor_n_if #(.N_BAT(4), .W(8)) bus2 ();

  battery_monitor_n #(.N_BAT(2), .W(4), .HOLD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  battery_monitor_n #(.N_BAT(4), .W(8), .HOLD(1)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic al(input logic a);
`ifdef BATMON_ALARM_EN
    return a;
`else
    return 1'b0;
`endif
  endfunction

  // Scan starts in the current cycle (cycle 0); results checked in cycle 4.
  task automatic scan(input string tag, input logic [7:0] b, input logic [4:0] s,
                      input logic [1:0] d, input logic [4:0] lv, input logic a);
    bus.bat    = b;
    bus.sample = 1'b1;
    step();
    bus.sample = 1'b0;
    check({tag, "_busy_c1"},  32'(bus.busy),  32'd1);
    check({tag, "_valid_c1"}, 32'(bus.valid), 32'd0);
    step();
    step();
    check({tag, "_busy_c3"},  32'(bus.busy),  32'd1);
    check({tag, "_valid_c3"}, 32'(bus.valid), 32'd0);
    step();
    check({tag, "_valid_c4"}, 32'(bus.valid), 32'd1);
    check({tag, "_busy_c4"},  32'(bus.busy),  32'd0);
    check({tag, "_sum"},      32'(bus.sum),   32'(s));
    check({tag, "_dis"},      32'(bus.discharged), 32'(d));
    check({tag, "_level"},    32'(bus.level), 32'(lv));
    check({tag, "_alarm"},    32'(bus.alarm), 32'(al(a)));
  endtask

  task automatic scan2(input string tag, input logic [31:0] b, input logic [9:0] s,
                       input logic [3:0] d, input logic [4:0] lv, input logic a);
    bus2.bat    = b;
    bus2.sample = 1'b1;
    step();
    bus2.sample = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check({tag, "_valid_pre"}, 32'(bus2.valid), 32'd0);
      check({tag, "_busy"},      32'(bus2.busy),  32'd1);
      step();
    end
    check({tag, "_valid_c6"}, 32'(bus2.valid), 32'd1);
    check({tag, "_sum"},      32'(bus2.sum),   32'(s));
    check({tag, "_dis"},      32'(bus2.discharged), 32'(d));
    check({tag, "_level"},    32'(bus2.level), 32'(lv));
    check({tag, "_alarm"},    32'(bus2.alarm), 32'(al(a)));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_sum"},   32'(bus.sum),   32'd0);
    check({tag, "_dis"},   32'(bus.discharged), 32'd0);
    check({tag, "_level"}, 32'(bus.level), 32'd0);
    check({tag, "_alarm"}, 32'(bus.alarm), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n       = 1'b0;
    bus.sample  = 1'b0;
    bus.bat     = '0;
    bus2.sample = 1'b0;
    bus2.bat    = '0;
    step();
    // Reset dominates a simultaneous sample request.
    bus.sample = 1'b1;
    step();
    bus.sample = 1'b0;
    check_reset("rst");
    check("rst2_level", 32'(bus2.level), 32'd0);
    check("rst2_sum",   32'(bus2.sum),   32'd0);
    rst_n = 1'b1;
    step();

    scan("full1", 8'hFF, 5'd30, 2'b00, 5'b00000, 1'b0);
    scan("full2", 8'hFF, 5'd30, 2'b00, 5'b10000, 1'b0);

    scan("dis1",  8'h50, 5'd5,  2'b01, 5'b10000, 1'b0);
    scan("dis2",  8'h50, 5'd5,  2'b01, 5'b00010, 1'b1);
    scan("dis3",  8'h55, 5'd10, 2'b00, 5'b00010, 1'b0);

    scan("ff1",   8'hFF, 5'd30, 2'b00, 5'b00010, 1'b0);
    scan("ff2",   8'hFF, 5'd30, 2'b00, 5'b10000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      scan("alt12", 8'h66, 5'd12, 2'b00, 5'b10000, 1'b0);
      scan("alt30", 8'hFF, 5'd30, 2'b00, 5'b10000, 1'b0);
    end
    scan("med1",  8'h66, 5'd12, 2'b00, 5'b10000, 1'b0);
    scan("med2",  8'h66, 5'd12, 2'b00, 5'b00100, 1'b0);

    scan("s11a",  8'h56, 5'd11, 2'b00, 5'b00100, 1'b0);
    scan("s11b",  8'h56, 5'd11, 2'b00, 5'b00010, 1'b0);
    scan("s19a",  8'h9A, 5'd19, 2'b00, 5'b00010, 1'b0);
    scan("s19b",  8'h9A, 5'd19, 2'b00, 5'b01000, 1'b0);
    scan("s29a",  8'hEF, 5'd29, 2'b00, 5'b01000, 1'b0);
    scan("s4a",   8'h22, 5'd4,  2'b00, 5'b01000, 1'b0);
    scan("s4b",   8'h22, 5'd4,  2'b00, 5'b00010, 1'b0);
    scan("s3a",   8'h21, 5'd3,  2'b00, 5'b00010, 1'b0);
    scan("s3b",   8'h21, 5'd3,  2'b00, 5'b00001, 1'b1);

    // Sample held high: a scan every 4 cycles, busy low only on the restart cycle.
    bus.sample = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) bus.sample = 1'b0;
      step();
      check("hold_busy",  32'(bus.busy),  32'((k % 4) != 0));
      check("hold_valid", 32'(bus.valid), 32'((k % 4) == 0));
    end
    step();
    check("hold_idle_busy", 32'(bus.busy), 32'd0);

    // Reset asserted in cycle 2 of a scan.
    bus.bat    = 8'hFF;
    bus.sample = 1'b1;
    step();
    bus.sample = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset("midrst");
    step();
    check("midrst_valid_a", 32'(bus.valid), 32'd0);
    step();
    check("midrst_valid_b", 32'(bus.valid), 32'd0);
    scan("post1", 8'hFF, 5'd30, 2'b00, 5'b00000, 1'b0);
    scan("post2", 8'hFF, 5'd30, 2'b00, 5'b10000, 1'b0);

    scan2("big_full", 32'hFFFF_FFFF, 10'd1020, 4'b0000, 5'b10000, 1'b0);
    scan2("big_high", 32'hFFFF_FF00, 10'd765,  4'b0001, 5'b01000, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
